serialize_arb: RTL
==================

Name: serialize_arb

Overview:
- Parametrised successor to the two-channel argument serializer: merges ARGN strobe/ready argument channels into one tagged result stream.
- Adds selectable arbitration mode (barrier round or free-running round-robin) and a DEPTH-entry output FIFO with occupancy count.
- Adds a round-complete pulse.
- Sits between parallel argument producers and a single serial consumer (e.g. a shared arithmetic unit or link).

Parameters:
- ARGW, 16: argument data width in bits.
- ARGN, 4: number of argument channels, 1..64.
- DEPTH, 4: output FIFO entries; power of two, >= 2.
- MODE, 0: 0 = barrier round (each channel accepted once per round); 1 = round-robin (no barrier).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- arg_stb  input  ARGN  per-channel valid.
- arg_dat  input  ARGN*ARGW  channel n data at bits [n*ARGW +: ARGW].
- arg_rdy  output  ARGN  per-channel ready; one-hot or zero.
- res_stb  output  1  result valid.
- res_dat  output  IDXW+ARGW  {channel index, data}; IDXW = max(1, clog2(ARGN)).
- res_rdy  input  1  consumer ready.
- res_cnt  output  clog2(DEPTH)+1  FIFO occupancy.
- rnd  output  1  one-cycle pulse when a barrier round completes (MODE 0 only; tied 0 in MODE 1).

Behaviour:
- Reset (rst==0 at clk edge):
  - FIFO emptied; res_stb=0, res_cnt=0, res_dat=0, rnd=0.
  - Mask and round-robin pointer cleared to 0.
  - In-flight FIFO contents are discarded; arg_rdy=0 while rst==0.
- Accept: channel n is accepted when arg_stb[n] & arg_rdy[n]. At most one accept per cycle.
- arg_rdy:
  - Combinational from arg_stb, mask/pointer and full.
  - All zero when FIFO full (res_cnt==DEPTH), including when a pop occurs the same cycle (no full pass-through).
  - Otherwise the grant bit is set, or all zero if no eligible request.
- MODE 0 grant:
  - Eligible = arg_stb & ~msk; grant the lowest eligible index.
  - On accept: if (msk|grant)==all ones, msk<=0 and rnd<=1 next cycle; else msk<=msk|grant.
  - Requests on masked channels wait; no starvation across rounds.
- MODE 1 grant:
  - Search from ptr upward with wrap; grant the first requesting channel.
  - On accept, ptr <= (granted index + 1) mod ARGN. ptr is unchanged when nothing is accepted.
- ARGN==1: always grant channel 0; index field is 1 bit, value 0. In MODE 0, rnd pulses after every accept.
- FIFO:
  - Push on accept, writing {index, arg_dat slice}. Pop on res_stb & res_rdy.
  - res_stb = (res_cnt != 0). res_dat = head entry, stable while res_stb & ~res_rdy.
  - Latency: accept at cycle t -> res_stb=1 with that entry at t+1 if the FIFO was empty.
  - Simultaneous push and pop: res_cnt unchanged, order preserved.
  - Read/write pointers wrap modulo DEPTH.
- res_cnt: push only +1, pop only -1, both or neither unchanged; never exceeds DEPTH.
- Ordering: results leave in accept order; no reordering or drops.

Test Plan:
- MODE 0, ARGN=4, DEPTH=4; arg_stb=4'b1111 with data 0x000A/0x000B/0x000C/0x000D, res_rdy=1:
  - Required: one accept per cycle in order 0,1,2,3.
  - res_dat = {2'd0,0x000A}, {2'd1,0x000B}, {2'd2,0x000C}, {2'd3,0x000D}.
  - rnd pulses once, one cycle after the ch3 accept.
- MODE 0, ch0 held valid continuously, ch2 valid once:
  - Required: ch0 accepted once, then ch2; ch0 waits until the round completes.
  - Round completes only after ch1 and ch3 are also accepted.
- MODE 1, all four channels valid, res_rdy=1:
  - Required: grants 0,1,2,3,0,1 on consecutive cycles; rnd stays 0.
- Backpressure, res_rdy=0, all channels valid:
  - Required: four accepts, then res_cnt=4 and arg_rdy=0.
  - With res_rdy=1 for one cycle: res_cnt drops to 3, then a new accept restores 4; output order is intact.
- Simultaneous push and pop at res_cnt=2:
  - Required: res_cnt stays 2 and the head advances.
- Reset mid-stream, rst=0 for one cycle with res_cnt=3 and msk=4'b0011:
  - Required: next cycle res_stb=0, res_cnt=0, res_dat=0, msk=0, arg_rdy=0.
  - First grant after reset is channel 0.

Source files
------------

// File: rtl/serialize_arb.sv
// Merges ARGN strobe/ready argument channels into one {index, data} result stream
// through a DEPTH-entry FIFO, with barrier-round (MODE 0) or round-robin (MODE 1) arbitration.
module serialize_arb #(
    parameter int ARGW  = 16,
    parameter int ARGN  = 4,
    parameter int DEPTH = 4,
    parameter int MODE  = 0,
    localparam int IDXW = (ARGN > 1) ? $clog2(ARGN) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ARGN-1:0]      arg_stb,
    input  logic [ARGN*ARGW-1:0] arg_dat,
    output logic [ARGN-1:0]      arg_rdy,
    output logic                 res_stb,
    output logic [IDXW+ARGW-1:0] res_dat,
    input  logic                 res_rdy,
    output logic [CW-1:0]        res_cnt,
    output logic                 rnd
);

    logic [ARGN-1:0]      msk_q, msk_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic                 rnd_q, rnd_d;
    logic [IDXW+ARGW-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [CW-1:0]        cnt_q;

    logic [ARGN-1:0]      cand;
    logic                 found;
    int                   s;
    logic [IDXW-1:0]      gidx;
    logic [ARGW-1:0]      wdat;
    logic                 full, push, pop;

    // Candidates are either unmasked requests, or requests rotated so bit 0 is ptr.
    always_comb begin
        cand  = (MODE == 0) ? (arg_stb & ~msk_q) : ARGN'({arg_stb, arg_stb} >> ptr_q);
        found = 1'b0;
        s     = 0;
        for (int j = ARGN - 1; j >= 0; j--) begin
            if (cand[j]) begin
                found = 1'b1;
                s     = j;
            end
        end
        if (MODE != 0) begin
            s = s + int'(ptr_q);
            if (s >= ARGN) s = s - ARGN;
        end
        gidx = IDXW'(s);
    end

    always_comb begin
        wdat = '0;
        for (int j = 0; j < ARGN; j++) begin
            if (int'(gidx) == j) wdat = arg_dat[j*ARGW +: ARGW];
        end
    end

    assign full    = (cnt_q == CW'(DEPTH));
    assign arg_rdy = (rst && !full && found) ? (ARGN'(1) << gidx) : '0;
    assign push    = |(arg_stb & arg_rdy);
    assign pop     = res_stb & res_rdy;

    always_comb begin
        msk_d = msk_q;
        ptr_d = ptr_q;
        rnd_d = 1'b0;
        if (push) begin
            if (MODE == 0) begin
                if ((msk_q | arg_rdy) == {ARGN{1'b1}}) begin
                    msk_d = '0;
                    rnd_d = 1'b1;
                end else begin
                    msk_d = msk_q | arg_rdy;
                end
            end
            ptr_d = (int'(gidx) + 1 >= ARGN) ? '0 : gidx + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            msk_q <= '0;
            ptr_q <= '0;
            rnd_q <= 1'b0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            msk_q <= msk_d;
            ptr_q <= ptr_d;
            rnd_q <= rnd_d;
            if (push) begin
                mem_q[wr_q] <= {gidx, wdat};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Empty FIFO presents zero so stale entries never leak out after reset.
    assign res_stb = (cnt_q != '0);
    assign res_dat = res_stb ? mem_q[rd_q] : '0;
    assign res_cnt = cnt_q;
    assign rnd     = rnd_q;

endmodule
